// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The counter sits on the slave side; whoever drives the controls uses master.
interface updown_mod_counter_if #(
    parameter int unsigned DATA_WIDTH = 4
) ();
    logic                  en;
    logic                  load_en;
    logic                  up_dn;
    logic [DATA_WIDTH-1:0] d;
    logic [DATA_WIDTH-1:0] q;
    logic                  tc;
    logic                  wrap;

    modport master (
        output en,
        output load_en,
        output up_dn,
        output d,
        input  q,
        input  tc,
        input  wrap
    );

    modport slave (
        input  en,
        input  load_en,
        input  up_dn,
        input  d,
        output q,
        output tc,
        output wrap
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter modulo MAX_COUNT+1, with wrap or saturate at the boundaries.
// tc is combinational; wrap is a registered one-cycle pulse after a boundary wrap.
module updown_mod_counter #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned MAX_COUNT  = 2**DATA_WIDTH - 1,
    parameter bit          SATURATE   = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    updown_mod_counter_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] MaxVal = DATA_WIDTH'(MAX_COUNT);

    logic [DATA_WIDTH-1:0] q_d, q_q;
    logic                  wrap_d, wrap_q;
    logic                  at_max, at_zero;

    assign at_max  = (q_q == MaxVal);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.load_en) begin
            // Out-of-range loads clamp so q never leaves 0..MAX_COUNT.
            q_d = (bus.d > MaxVal) ? MaxVal : bus.d;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (!at_max) begin
                    q_d = q_q + DATA_WIDTH'(1);
                end else if (!SATURATE) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - DATA_WIDTH'(1);
                end else if (!SATURATE) begin
                    q_d    = MaxVal;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.en && !bus.load_en && (bus.up_dn ? at_max : at_zero);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised and directed bench for updown_mod_counter; a wrapping and a saturating
// instance share one stimulus stream and are checked against an integer model.
module tb_updown_mod_counter;
    localparam int unsigned W = 4;
    localparam int M = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, load_en, up_dn;
    logic [W-1:0] d;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: index 0 = wrapping instance, 1 = saturating instance.
    int mq[2];
    int mw[2];

    updown_mod_counter_if #(.DATA_WIDTH(W)) bus_w ();
    updown_mod_counter_if #(.DATA_WIDTH(W)) bus_s ();

    assign bus_w.en      = en;
    assign bus_w.load_en = load_en;
    assign bus_w.up_dn   = up_dn;
    assign bus_w.d       = d;
    assign bus_s.en      = en;
    assign bus_s.load_en = load_en;
    assign bus_s.up_dn   = up_dn;
    assign bus_s.d       = d;

    updown_mod_counter #(.DATA_WIDTH(W), .MAX_COUNT(M), .SATURATE(1'b0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    updown_mod_counter #(.DATA_WIDTH(W), .MAX_COUNT(M), .SATURATE(1'b1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_tc(input int i);
        if (!en || load_en) return 0;
        if (up_dn) return (mq[i] == M) ? 1 : 0;
        return (mq[i] == 0) ? 1 : 0;
    endfunction

    // One rising edge of the reference behaviour, using modulo arithmetic.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit sat = (i == 1);
            int nxt = mq[i];
            int wr  = 0;
            if (load_en) begin
                nxt = (int'(d) > M) ? M : int'(d);
            end else if (en) begin
                bit boundary = up_dn ? (mq[i] == M) : (mq[i] == 0);
                if (boundary && sat) begin
                    nxt = mq[i];
                end else begin
                    nxt = up_dn ? (mq[i] + 1) % (M + 1) : (mq[i] + M) % (M + 1);
                    wr  = boundary ? 1 : 0;
                end
            end
            mq[i] = nxt;
            mw[i] = wr;
        end
    endtask

    task automatic step(input bit r, input bit l, input bit e, input bit u,
                        input logic [W-1:0] dv, input string tag);
        @(negedge clk);
        reset   = r;
        load_en = l;
        en      = e;
        up_dn   = u;
        d       = dv;
        if (!r) begin
            mq = '{0, 0};
            mw = '{0, 0};
        end
        #1;
        check_eq({tag, " tc"},     int'(bus_w.tc), exp_tc(0));
        check_eq({tag, " tc_sat"}, int'(bus_s.tc), exp_tc(1));
        @(posedge clk);
        if (r) model_edge();
        #1;
        check_eq({tag, " q"},        int'(bus_w.q),    mq[0]);
        check_eq({tag, " wrap"},     int'(bus_w.wrap), mw[0]);
        check_eq({tag, " q_sat"},    int'(bus_s.q),    mq[1]);
        check_eq({tag, " wrap_sat"}, int'(bus_s.wrap), mw[1]);
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b0;
        load_en = 1'b0;
        up_dn   = 1'b0;
        d       = '0;
        mq      = '{0, 0};
        mw      = '{0, 0};
        #1;
        check_eq("reset q",    int'(bus_w.q),    0);
        check_eq("reset wrap", int'(bus_w.wrap), 0);
        check_eq("reset q_sat", int'(bus_s.q),   0);

        // Reset held, inputs ignored, then count up through the wrap.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, "rst_hold");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, "rst_hold");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'(i), "count_up");
        check_eq("count_up final", int'(bus_w.q), 2);

        // Load 2 then count down across zero.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, "load2");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "count_dn");
        check_eq("count_dn final", int'(bus_w.q), 8);

        // Clamped load, then load wins over count on the same edge, including at a boundary.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd14, "load_clamp");
        check_eq("load_clamp const", int'(bus_w.q), 9);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, "load_en_pri");
        check_eq("load_en_pri const", int'(bus_w.q), 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, "load9");
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, "load_at_tc");

        // Saturation at both ends.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, "load7");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "sat_up");
        check_eq("sat_up const", int'(bus_s.q), 9);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "load1");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "sat_dn");
        check_eq("sat_dn const", int'(bus_s.q), 0);

        // Asynchronous reset between edges while q = 5.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, "load5");
        #2;
        reset = 1'b0;
        mq    = '{0, 0};
        mw    = '{0, 0};
        #1;
        check_eq("async_rst q",     int'(bus_w.q), 0);
        check_eq("async_rst q_sat", int'(bus_s.q), 0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "rst_release");
        check_eq("rst_release const", int'(bus_w.q), 1);

        // Idle: nothing moves regardless of up_dn and d.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 1'(i), 4'($urandom_range(15)), "idle");
        check_eq("idle const", int'(bus_w.q), 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) != 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                 1'($urandom_range(1)), 4'($urandom_range(15)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, the counter width in bits.
REQ-002 The block SHALL have parameter MAX_COUNT, default 2**DATA_WIDTH-1, the terminal value; legal range 1..2**DATA_WIDTH-1.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 en  input  1  count enable.
REQ-007 load_en  input  1  synchronous parallel load request.
REQ-008 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-009 d  input  DATA_WIDTH  load value.
REQ-010 q  output  DATA_WIDTH  registered count.
REQ-011 tc  output  1  combinational terminal-count flag.
REQ-012 wrap  output  1  registered one-cycle wrap-event pulse.

Function
REQ-013 Per-edge priority SHALL be reset, then load_en, then en, then hold.
REQ-014 load_en=1 SHALL set q to d on the next edge, regardless of en and up_dn; if d > MAX_COUNT, q SHALL be set to MAX_COUNT.
REQ-015 load_en=0, en=1, up_dn=1, q < MAX_COUNT SHALL give q+1 on the next edge.
REQ-016 load_en=0, en=1, up_dn=0, q > 0 SHALL give q-1 on the next edge.
REQ-017 SATURATE=0, en=1, up_dn=1, q == MAX_COUNT SHALL give q = 0 on the next edge.
REQ-018 SATURATE=0, en=1, up_dn=0, q == 0 SHALL give q = MAX_COUNT on the next edge.
REQ-019 SATURATE=1 at either boundary, in the counting direction, SHALL leave q unchanged.
REQ-020 en=0 and load_en=0 SHALL hold q.
REQ-021 tc SHALL be 1 exactly when en=1 and load_en=0 and either (up_dn=1 and q == MAX_COUNT) or (up_dn=0 and q == 0); otherwise 0.
REQ-022 wrap SHALL be 1 for exactly one cycle after an edge on which the REQ-017/018 wrap transition occurred; otherwise 0.
REQ-023 wrap SHALL be 0 at all times when SATURATE=1.
REQ-024 A load on the same edge as a boundary SHALL take the load; wrap SHALL be 0 the next cycle.
REQ-025 A direction change takes effect on the same edge it is sampled; no pipeline delay.
REQ-026 All arithmetic SHALL be modulo MAX_COUNT+1; q SHALL never exceed MAX_COUNT after reset.

Reset
REQ-027 reset=0 SHALL immediately, without a clock edge, force q = 0 and wrap = 0.
REQ-028 While reset=0, q and wrap SHALL hold 0 and all other inputs are ignored; tc follows REQ-021 on q = 0.
REQ-029 Reset deassertion SHALL take effect synchronously; the first count occurs on the first rising edge with reset=1.
REQ-030 Reset asserted mid-count or mid-load SHALL abandon the operation; no partial value is retained.

Verification (DATA_WIDTH=4, MAX_COUNT=9, SATURATE=0 unless stated)
REQ-031 reset=0 for 2 cycles, then en=1, up_dn=1 for 12 cycles -> q = 0,1,...,9,0,1; wrap high for one cycle after q goes 9->0; tc high while q == 9.
REQ-032 load_en=1, d=4'b0010 for 1 cycle, then en=1, up_dn=0 for 4 cycles -> q = 2,1,0,9,8; wrap pulses once after the 0->9 step.
REQ-033 load_en=1, d=4'b1110 -> q = 9 (clamped); load_en=1 with en=1 on the same edge -> q = d, with no count applied.
REQ-034 SATURATE=1: count up from 7 for 5 cycles -> q = 8,9,9,9,9 and wrap stays 0; then count down from 1 -> q = 0,0 and wrap stays 0.
REQ-035 reset=0 asserted between clock edges while q = 5 -> q = 0 before the next edge; after release, en=1 -> q = 1 on the first edge.
REQ-036 en=0, up_dn toggling, d changing, load_en=0 for 5 cycles -> q unchanged, tc = 0, wrap = 0.
